dmem_store_buffer: RTL

Posted-write store buffer between the core's execute-stage data-memory interface and the data memory. Stores retire to the buffer in one cycle and drain to memory in the background over a req/ready handshake. Loads that hit a buffered address are forwarded with no stall. Loads that miss stall the core until memory returns data. The `empty` output lets the core confirm all stores have reached memory before it acts on `halt`.

---
 rtl/dmem_store_buffer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write store buffer between the execute-stage data
// port and data memory. Stores retire into a circular FIFO in one cycle and
// drain to memory in the background. Loads that hit a buffered address are
// forwarded from the youngest matching entry without stalling. Loads that miss
// stall the core and are issued to memory ahead of any pending drain.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_write,
  input  logic          core_read,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  output logic          empty,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  state_t        state;
  state_t        state_next;
  logic          mem_req_next;
  logic          mem_we_next;
  logic [AW-1:0] mem_addr_next;
  logic [DW-1:0] mem_wdata_next;

  logic          full;
  logic          push;
  logic          pop;
  logic          read_req;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          miss_pending;
  logic          load_done;

  // Handshake qualifiers; a simultaneous write+read is treated as a write only.
  assign full         = (count == CNT_FULL);
  assign read_req     = core_read & ~core_write;
  assign push         = core_write & ~full;
  assign pop          = (state == DRAIN) & mem_req & mem_ready;
  assign load_done    = (state == LOAD) & mem_req & mem_ready;
  assign miss_pending = read_req & ~hit;
  assign empty        = (count == '0) & (state == IDLE);

  // Forwarding search: walk oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic match;
      match    = ((PW+1)'(k) < count) && (addr_mem[head + PW'(k)] == core_addr);
      hit      = hit | match;
      hit_data = match ? data_mem[head + PW'(k)] : hit_data;
    end
  end

  // Core-side response: forwarded data, completed read data, otherwise zero.
  always_comb begin
    core_stall = (core_write & full) | (miss_pending & ~load_done);
    if (read_req && hit) begin
      core_rdata = hit_data;
    end else if (load_done) begin
      core_rdata = mem_rdata;
    end else begin
      core_rdata = '0;
    end
  end

  // Entry storage: capture address and data at the tail on an accepted store.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= core_addr;
      data_mem[tail] <= core_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; enqueue and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Memory-side state and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_next;
      mem_req   <= mem_req_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
    end
  end

  // Next-state: load misses take priority over draining; outputs hold until ready.
  always_comb begin
    state_next     = state;
    mem_req_next   = mem_req;
    mem_we_next    = mem_we;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    case (state)
      IDLE: begin
        if (miss_pending) begin
          state_next     = LOAD;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = core_addr;
          mem_wdata_next = '0;
        end else if (count != '0) begin
          state_next     = DRAIN;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b1;
          mem_addr_next  = addr_mem[head];
          mem_wdata_next = data_mem[head];
        end else begin
          state_next     = IDLE;
        end
      end
      DRAIN, LOAD: begin
        if (mem_req && mem_ready) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
        end else begin
          state_next   = state;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

endmodule
